// File: rtl/rat_pkg.sv
// Shared constants for the RAT CPU: PC width, interrupt vector and flag bit indices.
package rat_pkg;

  localparam int unsigned RatPcW = 10;

  localparam logic [RatPcW-1:0] RatIntVector = 10'h3FF;

  // Bit positions of C and Z inside packed flag vectors (flag register, shadow copy).
  localparam int unsigned NumFlags = 2;
  localparam int unsigned FlagC    = 0;
  localparam int unsigned FlagZ    = 1;

  // Pack individual C/Z bits into a flag vector using the shared indices.
  function automatic logic [NumFlags-1:0] pack_flags(input logic c, input logic z);
    logic [NumFlags-1:0] f;
    f        = '0;
    f[FlagC] = c;
    f[FlagZ] = z;
    return f;
  endfunction

endpackage

// File: rtl/rat_sync_edge.sv
// Multi-flop synchronizer plus history flop producing a one-cycle rising-edge pulse.
// SyncStages must be in 2..4.
module rat_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  hist_q, hist_d;
  // Tracks which stages hold real samples since reset; bit SyncStages covers the history flop.
  logic [SyncStages:0]   vld_q, vld_d;

  // Next-state: shift the input through the chain, history follows the last stage.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
    hist_d = sync_q[SyncStages-1];
    vld_d  = {vld_q[SyncStages-1:0], 1'b1};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      vld_q  <= vld_d;
    end
  end

  // Only report an edge once the history flop holds a genuine sample, so a level that is
  // already high when reset releases is not mistaken for a new request.
  assign edge_o = sync_q[SyncStages-1] & ~hist_q & vld_q[SyncStages];

endmodule

// File: rtl/rat_int_ctrl.sv
// Interrupt front-end: edge-detected request, pending latch, enable flag, C/Z shadow and
// overrun reporting feeding the control unit's INT input.
module rat_int_ctrl
  import rat_pkg::*;
#(
  parameter int unsigned          SyncStages = 2,
  parameter int unsigned          PcW        = RatPcW,
  parameter logic [PcW-1:0]       IntVector  = RatIntVector
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           intr_i,
  input  logic           i_set_i,
  input  logic           i_clr_i,
  input  logic           int_ack_i,
  input  logic           c_flag_i,
  input  logic           z_flag_i,
  input  logic           ovr_clr_i,
  output logic           int_o,
  output logic           i_en_o,
  output logic           pend_o,
  output logic           shad_c_o,
  output logic           shad_z_o,
  output logic [PcW-1:0] int_vec_o,
  output logic           overrun_o
);

  logic                intr_edge;
  logic                pend_q, pend_d;
  logic                i_en_q, i_en_d;
  logic                ovr_q, ovr_d;
  logic [NumFlags-1:0] shad_q, shad_d;

  rat_sync_edge #(
    .SyncStages (SyncStages)
  ) u_sync_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (intr_i),
    .edge_o (intr_edge)
  );

  // Next-state for pending, enable, overrun and shadow flags.
  always_comb begin
    pend_d = pend_q;
    i_en_d = i_en_q;
    ovr_d  = ovr_q;
    shad_d = shad_q;

    // A new edge in the ack cycle is kept rather than lost.
    if (intr_edge) begin
      pend_d = 1'b1;
    end else if (int_ack_i) begin
      pend_d = 1'b0;
    end

    if (intr_edge && pend_q && !int_ack_i) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end

    // Ack auto-disables; clear beats set when both strobes fire together.
    if (int_ack_i || i_clr_i) begin
      i_en_d = 1'b0;
    end else if (i_set_i) begin
      i_en_d = 1'b1;
    end

    if (int_ack_i) begin
      shad_d = pack_flags(c_flag_i, z_flag_i);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      i_en_q <= 1'b0;
      ovr_q  <= 1'b0;
      shad_q <= '0;
    end else begin
      pend_q <= pend_d;
      i_en_q <= i_en_d;
      ovr_q  <= ovr_d;
      shad_q <= shad_d;
    end
  end

  // Outputs: INT drops in the ack cycle itself so the control unit sees a single request.
  always_comb begin
    int_o     = pend_q & i_en_q & ~int_ack_i;
    i_en_o    = i_en_q;
    pend_o    = pend_q;
    overrun_o = ovr_q;
    shad_c_o  = shad_q[FlagC];
    shad_z_o  = shad_q[FlagZ];
    int_vec_o = IntVector;
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Self-checking bench for rat_int_ctrl: expected output tuples are queued with the stimulus
// and compared once the DUT has updated.
module tb_rat_int_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       intr_i, i_set_i, i_clr_i, int_ack_i, c_flag_i, z_flag_i, ovr_clr_i;
  logic       int_o, i_en_o, pend_o, shad_c_o, shad_z_o, overrun_o;
  logic [9:0] int_vec_o;

  int n_vec = 0;
  int n_err = 0;

  // Expected tuple bits: {int, pend, i_en, shad_c, shad_z, overrun}
  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  rat_int_ctrl #(
    .SyncStages (2)
  ) u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .intr_i    (intr_i),
    .i_set_i   (i_set_i),
    .i_clr_i   (i_clr_i),
    .int_ack_i (int_ack_i),
    .c_flag_i  (c_flag_i),
    .z_flag_i  (z_flag_i),
    .ovr_clr_i (ovr_clr_i),
    .int_o     (int_o),
    .i_en_o    (i_en_o),
    .pend_o    (pend_o),
    .shad_c_o  (shad_c_o),
    .shad_z_o  (shad_z_o),
    .int_vec_o (int_vec_o),
    .overrun_o (overrun_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] st(input logic i, input logic p, input logic e,
                                    input logic c, input logic z, input logic o);
    return {i, p, e, c, z, o};
  endfunction

  task automatic push_exp(input string tag, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: got 0 entries, want 1");
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".int"},  32'(int_o),     32'(e.v[5]));
      check_eq({e.tag, ".pend"}, 32'(pend_o),    32'(e.v[4]));
      check_eq({e.tag, ".ien"},  32'(i_en_o),    32'(e.v[3]));
      check_eq({e.tag, ".sc"},   32'(shad_c_o),  32'(e.v[2]));
      check_eq({e.tag, ".sz"},   32'(shad_z_o),  32'(e.v[1]));
      check_eq({e.tag, ".ovr"},  32'(overrun_o), 32'(e.v[0]));
    end
  endtask

  // Queue the expectation for the current stimulus, clock once, compare 1 ns after the edge.
  task automatic tick(input string tag, input logic [5:0] v);
    push_exp(tag, v);
    @(posedge clk_i);
    #1;
    pop_cmp();
  endtask

  // Compare without a clock edge (combinational or asynchronous effects).
  task automatic now(input string tag, input logic [5:0] v);
    push_exp(tag, v);
    pop_cmp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni    = 1'b0;
    intr_i    = 1'b1;
    i_set_i   = 1'b0;
    i_clr_i   = 1'b0;
    int_ack_i = 1'b0;
    c_flag_i  = 1'b0;
    z_flag_i  = 1'b0;
    ovr_clr_i = 1'b0;

    // Reset with the request line high; release must not create an edge.
    repeat (3) @(posedge clk_i);
    #1;
    now("rst_hold", st(0, 0, 0, 0, 0, 0));
    check_eq("rst_vec", 32'(int_vec_o), 32'h3FF);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) tick("rst_hi", st(0, 0, 0, 0, 0, 0));

    // Latency: edge sampled at n shows as PEND/INT after n+2.
    intr_i  = 1'b0;
    i_set_i = 1'b1;
    tick("lat_sei", st(0, 0, 1, 0, 0, 0));
    i_set_i = 1'b0;
    for (int i = 0; i < 3; i++) tick("lat_low", st(0, 0, 1, 0, 0, 0));
    intr_i = 1'b1;
    tick("lat_n",  st(0, 0, 1, 0, 0, 0));
    tick("lat_n1", st(0, 0, 1, 0, 0, 0));
    tick("lat_n2", st(1, 1, 1, 0, 0, 0));

    // Acknowledge with C=1, Z=0.
    int_ack_i = 1'b1;
    c_flag_i  = 1'b1;
    #1;
    now("ack_in", st(0, 1, 1, 0, 0, 0));
    tick("ack", st(0, 0, 0, 1, 0, 0));
    int_ack_i = 1'b0;
    c_flag_i  = 1'b0;
    tick("ack_post", st(0, 0, 0, 1, 0, 0));

    // Masked request stays pending, INT follows I_SET by one cycle.
    intr_i = 1'b0;
    for (int i = 0; i < 3; i++) tick("msk_low", st(0, 0, 0, 1, 0, 0));
    intr_i = 1'b1;
    tick("msk_n",  st(0, 0, 0, 1, 0, 0));
    tick("msk_n1", st(0, 0, 0, 1, 0, 0));
    tick("msk_pend", st(0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 20; i++) tick("msk_hold", st(0, 1, 0, 1, 0, 0));
    i_set_i = 1'b1;
    tick("msk_sei", st(1, 1, 1, 1, 0, 0));
    i_set_i = 1'b0;

    // Edge in the ack cycle: request is kept, enable drops, flags snapshot C=0, Z=1.
    intr_i = 1'b0;
    for (int i = 0; i < 3; i++) tick("sim_low", st(1, 1, 1, 1, 0, 0));
    intr_i = 1'b1;
    tick("sim_n",  st(1, 1, 1, 1, 0, 0));
    tick("sim_n1", st(1, 1, 1, 1, 0, 0));
    int_ack_i = 1'b1;
    z_flag_i  = 1'b1;
    tick("sim_ack", st(0, 1, 0, 0, 1, 0));
    int_ack_i = 1'b0;
    z_flag_i  = 1'b0;
    for (int i = 0; i < 3; i++) tick("sim_mask", st(0, 1, 0, 0, 1, 0));
    i_set_i = 1'b1;
    tick("sim_sei", st(1, 1, 1, 0, 1, 0));
    i_set_i = 1'b0;

    // Plain ack clears the request, snapshot C=1, Z=1.
    int_ack_i = 1'b1;
    c_flag_i  = 1'b1;
    z_flag_i  = 1'b1;
    tick("clr_ack", st(0, 0, 0, 1, 1, 0));
    int_ack_i = 1'b0;
    c_flag_i  = 1'b0;
    z_flag_i  = 1'b0;

    // Set alone, then set together with clear.
    i_set_i = 1'b1;
    tick("ien_set", st(0, 0, 1, 1, 1, 0));
    i_clr_i = 1'b1;
    tick("ien_both", st(0, 0, 0, 1, 1, 0));
    i_set_i = 1'b0;
    i_clr_i = 1'b0;

    // Overrun: two 2-high/3-low bursts without ack.
    intr_i = 1'b0;
    for (int i = 0; i < 3; i++) tick("ovr_low0", st(0, 0, 0, 1, 1, 0));
    intr_i = 1'b1;
    for (int i = 0; i < 2; i++) tick("ovr_hi1", st(0, 0, 0, 1, 1, 0));
    intr_i = 1'b0;
    tick("ovr_e1", st(0, 1, 0, 1, 1, 0));
    for (int i = 0; i < 2; i++) tick("ovr_low1", st(0, 1, 0, 1, 1, 0));
    intr_i = 1'b1;
    for (int i = 0; i < 2; i++) tick("ovr_hi2", st(0, 1, 0, 1, 1, 0));
    intr_i = 1'b0;
    tick("ovr_e2", st(0, 1, 0, 1, 1, 1));
    for (int i = 0; i < 2; i++) tick("ovr_low2", st(0, 1, 0, 1, 1, 1));
    ovr_clr_i = 1'b1;
    tick("ovr_clr", st(0, 1, 0, 1, 1, 0));
    ovr_clr_i = 1'b0;
    intr_i = 1'b1;
    for (int i = 0; i < 2; i++) tick("ovr_hi3", st(0, 1, 0, 1, 1, 0));
    intr_i    = 1'b0;
    ovr_clr_i = 1'b1;
    tick("ovr_e3clr", st(0, 1, 0, 1, 1, 1));
    ovr_clr_i = 1'b0;
    tick("ovr_sticky", st(0, 1, 0, 1, 1, 1));

    // Asynchronous reset in the middle of a cycle clears everything without a clock edge.
    i_set_i = 1'b1;
    tick("isr", st(1, 1, 1, 1, 1, 1));
    i_set_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    now("async_rst", st(0, 0, 0, 0, 0, 0));
    check_eq("async_vec", 32'(int_vec_o), 32'h3FF);
    tick("rst_hold2", st(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rat_int_ctrl.md
Name: rat_int_ctrl

Overview:
- Interrupt front-end of the RAT CPU. Sits directly upstream of the control unit and drives its INT input.
- Synchronizes and edge-detects the external interrupt pin, holds a pending request, and gates it with the interrupt-enable flag managed by the control unit's I_SET/I_CLR strobes.
- On acknowledge, snapshots C/Z into shadow flags for RETI restore and presents the fixed interrupt vector to the PC mux.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on INTR_IN (legal range 2..4)
- PC_W, 10, program-counter width
- INT_VECTOR, 10'h3FF, ISR address driven on INT_VEC

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RESET_N  in  1  reset, asynchronous and active-low
- INTR_IN  in  1  raw external interrupt request, asynchronous, rising-edge sensitive
- I_SET  in  1  from control unit: set interrupt enable (SEI, RETIE)
- I_CLR  in  1  from control unit: clear interrupt enable (CLI, RETID)
- INT_ACK  in  1  from control unit: one-cycle pulse in its interrupt state
- C_FLAG  in  1  current carry flag
- Z_FLAG  in  1  current zero flag
- OVR_CLR  in  1  clears OVERRUN
- INT  out  1  interrupt request to control unit
- I_EN  out  1  interrupt-enable flag
- PEND  out  1  pending request (unmasked)
- SHAD_C  out  1  shadow carry, restored by RETI
- SHAD_Z  out  1  shadow zero, restored by RETI
- INT_VEC  out  PC_W  constant INT_VECTOR
- OVERRUN  out  1  sticky: an edge arrived while a request was already pending

Behaviour:
- Reset: RESET_N low clears all of the following, asynchronously: synchronizer chain, edge-history flop, PEND, I_EN, SHAD_C, SHAD_Z, OVERRUN. INT therefore reads 0. INT_VEC is always INT_VECTOR.
- Reset mid-operation discards any pending request. A high INTR_IN level present at reset release does not produce an edge.
- Synchronizer: INTR_IN passes through SYNC_STAGES flops. The last stage, s, feeds a history flop, h.
- Edge detect: edge = s & ~h.
- Latency: INTR_IN first sampled high at clock edge n → PEND high after edge n+SYNC_STAGES → INT high in the same cycle if I_EN=1.
- Pulse width: INTR_IN must be high for ≥1 clock to be seen. Repeated edges need ≥1 low sample between them.
- INT = PEND & I_EN & ~INT_ACK. It is combinational from registers plus the ack input, and never high during reset.
- PEND update priority, highest first:
  1. edge → PEND stays or becomes 1 (edge in the ack cycle wins; the new request is held)
  2. INT_ACK → PEND 0
  3. otherwise PEND holds
- OVERRUN: set on edge while PEND=1 and no INT_ACK that cycle. Cleared by OVR_CLR; set wins if both occur in the same cycle.
- I_EN update priority, highest first:
  1. INT_ACK → 0 (hardware auto-disable on entry)
  2. I_CLR → 0
  3. I_SET → 1
  4. otherwise hold
  - So I_SET together with I_CLR gives 0.
- Shadow flags: on INT_ACK, SHAD_C <= C_FLAG and SHAD_Z <= Z_FLAG, using values sampled in the ack cycle. At all other times they hold. A nested ack overwrites them.
- A masked request (I_EN=0) stays pending indefinitely. INT asserts in the cycle after I_SET is registered.
- INT_ACK while PEND=0 is tolerated: it still clears I_EN and snapshots the flags. No error is flagged.

Decomposition:
- Package rat_pkg:
  - PC_W
  - INT_VECTOR
  - flag-index constants (C, Z) shared with the control unit and flag register
- Sub-module rat_sync_edge: parameterized synchronizer plus history flop, output edge pulse. Reused later for switch/button inputs.
- The top level holds the PEND/I_EN/shadow/OVERRUN registers and the INT gating.

Test Plan:
- Reset: hold RESET_N=0 with INTR_IN=1, release → INT=0, PEND=0, I_EN=0, SHAD_C/Z=0, OVERRUN=0, INT_VEC=10'h3FF. Keep INTR_IN high 10 cycles → PEND stays 0.
- Latency: I_SET pulse, then INTR_IN 0→1 sampled at edge n → PEND=1 and INT=1 after edge n+2. Pulse INT_ACK with C_FLAG=1, Z_FLAG=0 → next cycle PEND=0, I_EN=0, SHAD_C=1, SHAD_Z=0, INT=0.
- Masking: I_EN=0, raise INTR_IN → PEND=1, INT=0 for 20 cycles. I_SET pulse → INT=1 the next cycle.
- Simultaneous events:
  - edge coincides with INT_ACK → PEND=1 after ack, I_EN=0, INT=0 until I_SET
  - I_SET and I_CLR in the same cycle → I_EN=0
- Overrun: two edges (each 2-cycle high, 3-cycle low) with no ack → OVERRUN=1, PEND=1. OVR_CLR → OVERRUN=0. OVR_CLR coincident with a third edge → OVERRUN=1.
- Async reset mid-ISR: PEND=1, I_EN=1, SHAD_C=1; drop RESET_N between clock edges → all outputs 0 immediately, without waiting for CLK.
